serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first payload, optional even
// parity, stop bit. Every output comes from a flop; the FSM state is exposed for debug.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        o_dbg_state
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Handshake: a word is taken on any posedge where load=1 and ready=1; ready is
    // high only in IDLE, so load is ignored for the whole frame.
    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_out;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_par_nxt;
    logic              w_done_nxt;
    logic              w_out_nxt;
    logic              w_bit_end;

    assign w_bit_end = (r_timer == T_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_bit_end ? '0 : r_timer + TW'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (load) begin
                    w_state_nxt = START;
                    w_shift_nxt = data_in;
                    w_par_nxt   = ^data_in;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == I_LAST) begin
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_idx_nxt   = r_idx + IW'(1);
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Line level is precomputed from the next state so it can be registered.
        case (w_state_nxt)
            START:   w_out_nxt = 1'b0;
            DATA:    w_out_nxt = w_shift_nxt[0];
            PARITY:  w_out_nxt = w_par_nxt;
            default: w_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_out   <= w_out_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign ready       = r_ready;
    assign out         = r_out;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
